// File: rtl/product_display_pkg.sv
// Shared types and constants for the product display: converter states,
// active-low seven-segment patterns and digit helpers.
package product_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  function automatic logic [3:0] add3_nibble(input logic [3:0] nibble);
    logic [3:0] result;
    if (nibble >= 4'd5) begin
      result = nibble + 4'd3;
    end else begin
      result = nibble;
    end
    return result;
  endfunction

endpackage

// File: rtl/product_display_if.sv
// Bus between the multiplier-side driver and the display stage:
// conversion handshake, BCD result and the seven-segment pins.
interface product_display_if;
  logic        start;
  logic [7:0]  product;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output start, product, input busy, done, bcd, an, seg, dp);
  modport slave  (input start, product, output busy, done, bcd, an, seg, dp);
endinterface

// File: rtl/product_display_bin2bcd.sv
// Iterative double-dabble converter: 8-bit binary to three BCD digits,
// eight ADD3/SHIFT rounds per conversion.
module bin2bcd
  import product_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  product,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic        busy_q, done_q;

  // Next-state logic; sr holds {scratch BCD, remaining binary}.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {12'd0, product};
          iter_d  = 3'd0;
          state_d = ADD3;
        end else begin
          state_d = IDLE;
        end
      end
      ADD3: begin
        sr_d    = {add3_nibble(sr_q[19:16]), add3_nibble(sr_q[15:12]),
                   add3_nibble(sr_q[11:8]), sr_q[7:0]};
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d   = {sr_q[18:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = sr_q[18:7];
          state_d = DONE;
        end else begin
          state_d = ADD3;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 20'd0;
      iter_q  <= 3'd0;
      bcd_q   <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/product_display.sv
// Product display top: BCD converter plus a three-slot multiplexed
// seven-segment scan with leading-zero blanking.
module product_display
  import product_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  product_display_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic        conv_busy, conv_done;
  logic [11:0] conv_bcd;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  slot_q, slot_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  digit;
  logic        blank;

  bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start),
    .product (bus.product),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Refresh counter and slot rotation 0 -> 1 -> 2 -> 0.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (slot_q == 2'd2) begin
        slot_d = 2'd0;
      end else begin
        slot_d = slot_q + 2'd1;
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Digit select with leading-zero blanking, then segment decode.
  always_comb begin
    digit = 4'd0;
    blank = 1'b1;
    case (slot_q)
      2'd0: begin
        digit = conv_bcd[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        digit = conv_bcd[7:4];
        blank = (conv_bcd[11:8] == 4'd0) && (conv_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        digit = conv_bcd[11:8];
        blank = (conv_bcd[11:8] == 4'd0);
      end
      default: begin
        digit = 4'd0;
        blank = 1'b1;
      end
    endcase
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(4'b0001 << slot_q);
      seg_d = seg_encode(digit);
    end
  end

  // Scan state and registered display pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= 2'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.busy = conv_busy;
  assign bus.done = conv_done;
  assign bus.bcd  = conv_bcd;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;

endmodule
